// File: rtl/ddr2_ui_responder.sv
// MIG DDR2 user-interface responder: AF/WDF FIFOs feed a 2-beat burst engine over a local array.
// Read beats return READ_LATENCY cycles after command pop; no read backpressure, producers throttle on afull.
module ddr2_ui_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    afull,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;
    logic [CW-1:0]    count_next;

    // A pop in the same cycle frees a slot, so a push to a full FIFO is still taken.
    assign full       = (count == CW'(DEPTH));
    assign pop_ok     = pop && (count != '0);
    assign push_ok    = push && (!full || pop_ok);
    assign overflow   = push && full && !pop_ok;
    assign count_next = count + CW'(push_ok) - CW'(pop_ok);
    assign head       = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            afull  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            afull <= (count_next >= CW'(AFULL_LVL));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr] <= push_data;
    end
endmodule

module ddr2_ui_responder #(
    parameter int APPDATA_WIDTH    = 128,
    parameter int INPUT_ADDR_WIDTH = 31,
    parameter int MEM_AW           = 10,
    parameter int AF_DEPTH         = 4,
    parameter int WDF_DEPTH        = 8,
    parameter int READ_LATENCY     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        app_af_wren,
    input  logic [INPUT_ADDR_WIDTH-1:0] app_af_addr,
    input  logic [2:0]                  app_af_cmd,
    input  logic                        app_wdf_wren,
    input  logic [APPDATA_WIDTH-1:0]    app_wdf_data,
    input  logic [APPDATA_WIDTH/8-1:0]  app_wdf_mask_data,
    output logic                        app_af_afull,
    output logic                        app_wdf_afull,
    output logic                        rd_data_valid,
    output logic [APPDATA_WIDTH-1:0]    rd_data_fifo_out,
    output logic                        err_flag
);
    localparam int MASK_W = APPDATA_WIDTH / 8;
    localparam int AF_W   = 3 + INPUT_ADDR_WIDTH;
    localparam int WDF_W  = MASK_W + APPDATA_WIDTH;
    localparam int LCW    = $clog2(READ_LATENCY + 1);
    localparam int ACW    = $clog2(AF_DEPTH) + 1;
    localparam int WCW    = $clog2(WDF_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, WR0, WR1, RD_WAIT, RD0, RD1} state_t;

    state_t                        state;
    state_t                        state_next;
    logic [LCW-1:0]                cnt;
    logic [LCW-1:0]                cnt_next;
    logic [MEM_AW-2:0]             line;
    logic                          load;
    logic                          illegal;

    logic [AF_W-1:0]               af_head;
    logic [ACW-1:0]                af_count;
    logic                          af_pop;
    logic                          af_ovf;
    logic [2:0]                    head_cmd;
    logic [INPUT_ADDR_WIDTH-1:0]   head_addr;
    logic                          addr_unused;

    logic [WDF_W-1:0]              wdf_head;
    logic [WCW-1:0]                wdf_count;
    logic                          wdf_pop;
    logic                          wdf_ovf;
    logic [MASK_W-1:0]             wdf_mask;
    logic [APPDATA_WIDTH-1:0]      wdf_data;

    logic [APPDATA_WIDTH-1:0]      mem [2**MEM_AW];
    logic                          wr_en;
    logic [MEM_AW-1:0]             wr_idx;

    ddr2_ui_fifo #(.WIDTH(AF_W), .DEPTH(AF_DEPTH), .AFULL_LVL(AF_DEPTH-1)) u_af (
        .clk       (clk),
        .rst       (rst),
        .push      (app_af_wren),
        .push_data ({app_af_cmd, app_af_addr}),
        .pop       (af_pop),
        .head      (af_head),
        .count     (af_count),
        .afull     (app_af_afull),
        .overflow  (af_ovf)
    );

    ddr2_ui_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH), .AFULL_LVL(WDF_DEPTH-2)) u_wdf (
        .clk       (clk),
        .rst       (rst),
        .push      (app_wdf_wren),
        .push_data ({app_wdf_mask_data, app_wdf_data}),
        .pop       (wdf_pop),
        .head      (wdf_head),
        .count     (wdf_count),
        .afull     (app_wdf_afull),
        .overflow  (wdf_ovf)
    );

    assign head_cmd    = af_head[AF_W-1 -: 3];
    assign head_addr   = af_head[INPUT_ADDR_WIDTH-1:0];
    assign addr_unused = ^{head_addr[INPUT_ADDR_WIDTH-1:MEM_AW], head_addr[0]};
    assign wdf_mask    = wdf_head[WDF_W-1 -: MASK_W];
    assign wdf_data    = wdf_head[APPDATA_WIDTH-1:0];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        af_pop     = 1'b0;
        wdf_pop    = 1'b0;
        load       = 1'b0;
        illegal    = 1'b0;
        case (state)
            IDLE: begin
                if (af_count != '0) begin
                    case (head_cmd)
                        3'b000: begin
                            // Both beats must already be queued so WR0/WR1 never starve.
                            if (wdf_count >= WCW'(2)) begin
                                af_pop     = 1'b1;
                                load       = 1'b1;
                                state_next = WR0;
                            end
                        end
                        3'b001: begin
                            af_pop     = 1'b1;
                            load       = 1'b1;
                            cnt_next   = LCW'(READ_LATENCY - 1);
                            state_next = RD_WAIT;
                        end
                        default: begin
                            af_pop  = 1'b1;
                            illegal = 1'b1;
                        end
                    endcase
                end
            end
            WR0: begin
                wdf_pop    = 1'b1;
                state_next = WR1;
            end
            WR1: begin
                wdf_pop    = 1'b1;
                state_next = IDLE;
            end
            RD_WAIT: begin
                cnt_next = cnt - LCW'(1);
                if (cnt == LCW'(1)) state_next = RD0;
            end
            RD0:     state_next = RD1;
            RD1:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read outputs are registered off the next state so the beat lands on entry to RD0/RD1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            line             <= '0;
            rd_data_valid    <= 1'b0;
            rd_data_fifo_out <= '0;
            err_flag         <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) line <= head_addr[MEM_AW-1:1];
            rd_data_valid <= (state_next == RD0) || (state_next == RD1);
            if (state_next == RD0)      rd_data_fifo_out <= mem[{line, 1'b0}];
            else if (state_next == RD1) rd_data_fifo_out <= mem[{line, 1'b1}];
            if (af_ovf || wdf_ovf || illegal) err_flag <= 1'b1;
        end
    end

    assign wr_en  = !rst && ((state == WR0) || (state == WR1));
    assign wr_idx = {line, (state == WR1)};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (!wdf_mask[i]) mem[wr_idx][8*i +: 8] <= wdf_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ddr2_ui_responder.sv
// Randomized scoreboard bench for ddr2_ui_responder against a word-array reference model.
module tb_ddr2_ui_responder;
    localparam int DW = 128;
    localparam int MW = DW / 8;
    localparam int AW = 31;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          app_af_wren = 1'b0;
    logic [AW-1:0] app_af_addr = '0;
    logic [2:0]    app_af_cmd = '0;
    logic          app_wdf_wren = 1'b0;
    logic [DW-1:0] app_wdf_data = '0;
    logic [MW-1:0] app_wdf_mask_data = '0;
    logic          app_af_afull;
    logic          app_wdf_afull;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data_fifo_out;
    logic          err_flag;

    ddr2_ui_responder #(
        .APPDATA_WIDTH(DW), .INPUT_ADDR_WIDTH(AW), .MEM_AW(10),
        .AF_DEPTH(4), .WDF_DEPTH(8), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .app_af_wren(app_af_wren), .app_af_addr(app_af_addr), .app_af_cmd(app_af_cmd),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
        .app_wdf_mask_data(app_wdf_mask_data),
        .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
        .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out),
        .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            when;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mdl [int];
    int            checks = 0;
    int            errors = 0;

    // Monitor: every valid beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rd_data_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: beat %h at cycle %0d, none outstanding", rd_data_fifo_out, cyc);
            end else begin
                e = sb.pop_front();
                if (rd_data_fifo_out !== e.data || (e.when >= 0 && cyc != e.when)) begin
                    errors++;
                    $display("FAIL rd_beat: got %h at cycle %0d, expected %h at cycle %0d",
                             rd_data_fifo_out, cyc, e.data, e.when);
                end
            end
        end
    end

    function automatic int word_of(input int addr, input int b);
        return ((addr / 2) % 512) * 2 + b;
    endfunction

    function automatic void apply_write(input int word, input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic [DW-1:0] w;
        w = mdl.exists(word) ? mdl[word] : '0;
        for (int i = 0; i < MW; i++) if (!m[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[word] = w;
    endfunction

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic push_af(input logic [2:0] cmd, input int addr, input bit wait_room);
        int g;
        g = 0;
        while (wait_room && app_af_afull && g < 2000) begin tick(); g++; end
        if (g >= 2000) begin
            checks++; errors++;
            $display("FAIL af_room_timeout: af_afull=%b expected 0", app_af_afull);
        end
        app_af_wren = 1'b1;
        app_af_cmd  = cmd;
        app_af_addr = AW'(addr);
        tick();
        app_af_wren = 1'b0;
    endtask

    task automatic push_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m);
        int g;
        g = 0;
        while (app_wdf_afull && g < 2000) begin tick(); g++; end
        if (g >= 2000) begin
            checks++; errors++;
            $display("FAIL wdf_room_timeout: wdf_afull=%b expected 0", app_wdf_afull);
        end
        app_wdf_wren      = 1'b1;
        app_wdf_data      = d;
        app_wdf_mask_data = m;
        tick();
        app_wdf_wren = 1'b0;
    endtask

    task automatic issue_write(input int addr, input logic [DW-1:0] d0, input logic [MW-1:0] m0,
                               input logic [DW-1:0] d1, input logic [MW-1:0] m1, input bit data_first);
        if (!data_first) begin push_af(3'b000, addr, 1'b1); gap(); end
        push_wdf(d0, m0);
        gap();
        push_wdf(d1, m1);
        if (data_first) begin gap(); push_af(3'b000, addr, 1'b1); end
        apply_write(word_of(addr, 0), d0, m0);
        apply_write(word_of(addr, 1), d1, m1);
    endtask

    task automatic issue_read(input int addr, input bit timed, input bit raw, input bit accepted);
        exp_t e;
        push_af(3'b001, addr, !raw);
        if (accepted) begin
            e.data = mdl[word_of(addr, 0)];
            e.when = timed ? cyc + RL : -1;
            sb.push_back(e);
            e.data = mdl[word_of(addr, 1)];
            e.when = timed ? cyc + RL + 1 : -1;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin tick(); g++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic settle();
        drain();
        repeat (30) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        repeat (3) tick();
        check1("reset_rd_valid", rd_data_valid, 1'b0);
        check1("reset_rd_data_zero", |rd_data_fifo_out, 1'b0);
        check1("reset_af_afull", app_af_afull, 1'b0);
        check1("reset_wdf_afull", app_wdf_afull, 1'b0);
        check1("reset_err", err_flag, 1'b0);
        rst = 1'b0;
        tick();

        // Define every word the test touches.
        for (int n = 0; n < 64; n += 2)
            issue_write(n, rand128(), '0, rand128(), '0, (n % 4) == 0);
        settle();

        // Write then read with exact latency.
        issue_write(16, {{15{8'hAA}}, 8'h01}, '0, {{15{8'hBB}}, 8'h02}, '0, 1'b1);
        settle();
        issue_read(16, 1'b1, 1'b0, 1'b1);
        settle();

        // Byte mask.
        issue_write(16, {16{8'hFF}}, '0, {16{8'hFF}}, '0, 1'b0);
        issue_write(16, '0, 16'h0001, '0, 16'hF0F0, 1'b1);
        issue_read(16, 1'b0, 1'b0, 1'b1);
        settle();

        // Data ahead of the command.
        push_wdf({4{32'h1234_5678}}, '0);
        push_wdf({4{32'h9ABC_DEF0}}, 16'h00FF);
        for (int k = 0; k < 5; k++) begin
            check1("wdf_afull_two_beats", app_wdf_afull, 1'b0);
            tick();
        end
        push_af(3'b000, 32, 1'b1);
        apply_write(word_of(32, 0), {4{32'h1234_5678}}, '0);
        apply_write(word_of(32, 1), {4{32'h9ABC_DEF0}}, 16'h00FF);
        issue_read(32, 1'b0, 1'b0, 1'b1);
        settle();

        // WDF almost-full threshold at 6 beats.
        for (int k = 0; k < 6; k++) begin
            push_wdf(rand128() ^ DW'(k), MW'($urandom));
            check1($sformatf("wdf_afull_after_%0d", k + 1), app_wdf_afull, k >= 5);
        end
        // Beats were pushed in pairs; rebuild the model from the same beats is not possible, so
        // pair them with three writes whose values are tracked through a read of fresh data below.
        push_af(3'b000, 48, 1'b1);
        push_af(3'b000, 50, 1'b1);
        push_af(3'b000, 52, 1'b1);
        settle();
        check1("wdf_afull_drained", app_wdf_afull, 1'b0);
        issue_write(48, rand128(), '0, rand128(), '0, 1'b0);
        issue_write(50, rand128(), '0, rand128(), '0, 1'b1);
        issue_write(52, rand128(), '0, rand128(), '0, 1'b0);
        issue_read(48, 1'b0, 1'b0, 1'b1);
        issue_read(52, 1'b0, 1'b0, 1'b1);
        settle();

        // AF thresholds and overflow while the engine is busy with a read.
        check1("err_before_overflow", err_flag, 1'b0);
        issue_read(0, 1'b1, 1'b1, 1'b1);
        tick();
        issue_read(2, 1'b0, 1'b1, 1'b1);
        issue_read(4, 1'b0, 1'b1, 1'b1);
        check1("af_afull_at_2", app_af_afull, 1'b0);
        issue_read(6, 1'b0, 1'b1, 1'b1);
        check1("af_afull_at_3", app_af_afull, 1'b1);
        issue_read(8, 1'b0, 1'b1, 1'b1);
        check1("err_full_no_drop", err_flag, 1'b0);
        issue_read(10, 1'b0, 1'b1, 1'b0);
        check1("err_after_overflow", err_flag, 1'b1);
        settle();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("err_cleared_by_rst", err_flag, 1'b0);
        check1("af_afull_after_rst", app_af_afull, 1'b0);

        // Illegal command.
        push_af(3'b010, 64, 1'b1);
        repeat (3) tick();
        check1("err_after_illegal", err_flag, 1'b1);
        settle();

        // Reset during RD_WAIT: no beats may appear afterwards.
        push_af(3'b001, 16, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check1("err_after_midread_rst", err_flag, 1'b0);
        check1("rd_valid_after_midread_rst", rd_data_valid, 1'b0);
        issue_read(16, 1'b1, 1'b0, 1'b1);
        settle();

        // Randomized mix.
        for (int n = 0; n < 60; n++) begin
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1)
                issue_write(a, rand128(), MW'($urandom), rand128(), MW'($urandom), $urandom_range(0, 1) == 1);
            else
                issue_read(a, 1'b0, 1'b0, 1'b1);
            gap();
        end
        settle();
        check1("err_after_random", err_flag, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr2_ui_responder.md
Name: ddr2_ui_responder

Overview:
- Synthesizable responder model of the MIG DDR2 user interface: the memory end of the cache-side data read/write adapter.
- Accepts address/command and write-data FIFO traffic, stores 128-bit beats in an internal array, and returns read bursts with fixed latency.
- Used in top-level CPU/NPU simulation and FPGA bring-up in place of the real MIG, so adapter and cache logic can be exercised without DDR2 hardware.

Parameters:
- APPDATA_WIDTH, 128, beat width; must be a multiple of 8.
- INPUT_ADDR_WIDTH, 31, width of app_af_addr.
- MEM_AW, 10, log2 of the number of APPDATA_WIDTH words in the array.
- AF_DEPTH, 4, address/command FIFO entries; power of 2.
- WDF_DEPTH, 8, write-data FIFO beats; power of 2, at least 4.
- READ_LATENCY, 4, cycles from command pop to the first read beat; at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- app_af_wren  in  1  push to the address/command FIFO.
- app_af_addr  in  INPUT_ADDR_WIDTH  command address.
- app_af_cmd  in  3  000 = write, 001 = read, others illegal.
- app_wdf_wren  in  1  push to the write-data FIFO.
- app_wdf_data  in  APPDATA_WIDTH  write beat.
- app_wdf_mask_data  in  APPDATA_WIDTH/8  byte mask; 1 = byte not written.
- app_af_afull  out  1  address FIFO almost full.
- app_wdf_afull  out  1  write-data FIFO almost full.
- rd_data_valid  out  1  rd_data_fifo_out valid this cycle.
- rd_data_fifo_out  out  APPDATA_WIDTH  read beat.
- err_flag  out  1  sticky error: overflow or illegal command.

Behaviour:
- Reset values: all outputs 0; both FIFOs emptied; FSM in IDLE; latency counter 0. The memory array is not cleared.
- A reset in any state aborts the operation: pending beats are lost and no further rd_data_valid is driven.
- Every command is a 2-beat burst. Beat b (0 or 1) of a command at address A uses word index {A[MEM_AW-1:1], b}; A[0] is ignored.
- AF FIFO:
  - Push when app_af_wren=1 and not full; stores {cmd, addr}.
  - app_af_afull = (count >= AF_DEPTH-1), registered from next-count so it updates in the same cycle as the push or pop.
- WDF FIFO:
  - Push when app_wdf_wren=1 and not full; stores {mask, data}.
  - app_wdf_afull = (count >= WDF_DEPTH-2).
- A push and a pop in the same cycle leave the count unchanged. This holds even when the FIFO is full, because the pop frees a slot and the push is accepted.
- A push to a full FIFO with no simultaneous pop is dropped and sets err_flag.
- FSM states: IDLE, WR0, WR1, RD_WAIT, RD0, RD1.
  - IDLE:
    - If the AF FIFO is non-empty and the head cmd is 000, wait until the WDF count is at least 2; then pop the AF FIFO (cycle T) and go to WR0.
    - If the head cmd is 001, pop at T, load the counter with READ_LATENCY-1, and go to RD_WAIT.
    - Any other cmd: pop, set err_flag, stay in IDLE.
  - WR0: pop one WDF beat, write it to word b=0 with byte mask applied (cycle T+1), go to WR1.
  - WR1: pop one WDF beat, write it to word b=1 (T+2), go to IDLE. The next command pop is possible at T+3.
  - RD_WAIT: decrement the counter; at 1, go to RD0.
  - RD0: rd_data_valid=1 with word b=0, registered, at cycle T+READ_LATENCY.
  - RD1: rd_data_valid=1 with word b=1 at T+READ_LATENCY+1, then IDLE.
- Commands complete strictly in order, so a read after a write to the same address returns the new data.
- rd_data_fifo_out holds its last value when rd_data_valid=0.
- Write beats may arrive before or after their command. Beats without a command simply wait in the WDF FIFO.
- No backpressure on the read return: the consumer must accept both beats.
- err_flag clears only on rst.

Test Plan:
1. Write then read:
   - Stimulus: af write at addr 0x10, WDF beats 0xAAAA…01 then 0xBBBB…02; then af read at 0x10.
   - Response: rd_data_valid high for exactly 2 consecutive cycles, READ_LATENCY cycles after the read pop, carrying 0xAAAA…01 then 0xBBBB…02.
2. Byte mask:
   - Stimulus: preload word 0x10 = all 0xFF; write with mask 16'h0001 and data all 0x00.
   - Response: reading back word 0 gives 0x00…00FF (byte 0 kept); word 1 follows its own mask.
3. Data before command:
   - Stimulus: push 2 WDF beats with no af entry for 5 cycles, then af write.
   - Response: no memory write before the af pop; data lands 1–2 cycles after the pop; app_wdf_afull stays 0.
4. FIFO thresholds and overflow:
   - Stimulus: push 5 af reads back-to-back with the FSM stalled in read.
   - Response: app_af_afull rises when the count reaches 3; the fifth push while full sets err_flag; exactly 4 read bursts return.
5. Illegal command and reset mid-read:
   - Stimulus: af cmd 3'b010; then a read with rst pulsed during RD_WAIT.
   - Response: err_flag=1 after the illegal pop; after rst, err_flag=0 and no rd_data_valid appears; previously written data is still readable afterwards.
